// File: rtl/clk_period_monitor.sv
// Receive-side monitor for a divided clock: synchronises clk_in, emits edge
// strobes, measures rise-to-rise period and tracks lock / loss-of-clock.
module clk_period_monitor #(
  parameter int unsigned D_EXPECT = 10000,
  parameter int unsigned TOL      = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_in,
  output logic        rise_pulse,
  output logic        fall_pulse,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        lost
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACQ    = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;
  localparam logic [1:0] S_LOST   = 2'd3;

  localparam logic [31:0] TMO    = 32'(TIMEOUT);
  localparam logic [31:0] P_LO   = 32'(D_EXPECT - TOL);
  localparam logic [31:0] P_HI   = 32'(D_EXPECT + TOL);
  localparam logic [31:0] LOCK_N = 32'(LOCK_CNT);

  logic        s1_q, s2_q, s3_q;
  logic        rise_q, fall_q, pv_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] good_q, good_d;
  logic [31:0] period_q, period_d;
  logic [1:0]  state_q, state_d;
  logic        pv_d;
  logic        r, f, timeout, in_tol;
  logic [31:0] p_meas;

  // Stage p0: three-flop synchroniser, edge detect on the settled pair
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= clk_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign r = s2_q & ~s3_q;
  assign f = ~s2_q & s3_q;

  // Stage p1: period measurement and lock FSM; a rise always beats timeout
  always_comb begin
    p_meas   = cnt_q + 32'd1;
    in_tol   = (p_meas >= P_LO) && (p_meas <= P_HI);
    timeout  = (cnt_q >= TMO);
    cnt_d    = r ? 32'd0 : (timeout ? cnt_q : cnt_q + 32'd1);
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    pv_d     = 1'b0;
    case (state_q)
      S_IDLE, S_LOST: begin
        if (r) begin
          state_d = S_ACQ;
          good_d  = 32'd0;
        end else if (timeout) begin
          state_d = S_LOST;
        end
      end
      S_ACQ: begin
        if (r) begin
          pv_d     = 1'b1;
          period_d = p_meas;
          if (in_tol) begin
            good_d = good_q + 32'd1;
            if (good_q + 32'd1 >= LOCK_N) state_d = S_LOCKED;
          end else begin
            good_d = 32'd0;
          end
        end else if (timeout) begin
          state_d = S_LOST;
        end
      end
      default: begin
        if (r) begin
          pv_d     = 1'b1;
          period_d = p_meas;
          if (!in_tol) begin
            state_d = S_ACQ;
            good_d  = 32'd0;
          end
        end else if (timeout) begin
          state_d = S_LOST;
        end
      end
    endcase
  end

  // Stage p2: registered strobes, period and state
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pv_q     <= 1'b0;
      cnt_q    <= 32'd0;
      good_q   <= 32'd0;
      period_q <= 32'd0;
      state_q  <= S_IDLE;
    end else begin
      rise_q   <= r;
      fall_q   <= f;
      pv_q     <= pv_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      state_q  <= state_d;
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign period_valid = pv_q;
  assign period       = period_q;
  assign locked       = (state_q == S_LOCKED);
  assign lost         = (state_q == S_LOST);

endmodule

// File: tb/tb_clk_period_monitor.sv
// Bench for clk_period_monitor: event-timeline reference model with per-cycle
// comparison, plus literal spot checks on lock, loss and reset behaviour.
module tb_clk_period_monitor;

  localparam int DE = 100;
  localparam int TL = 8;
  localparam int LC = 4;
  localparam int TO = 200;

  logic        clk, rst, clk_in;
  logic        rise_pulse, fall_pulse, period_valid, locked, lost;
  logic [31:0] period;

  clk_period_monitor #(.D_EXPECT(DE), .TOL(TL), .LOCK_CNT(LC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .period(period), .period_valid(period_valid),
    .locked(locked), .lost(lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: every clk_in level change seen at edge k becomes a strobe
  // after edge k+2; periods are gaps between rise-strobe edges.
  typedef enum {M_IDLE, M_ACQ, M_LOCK, M_LOST} mst_t;
  typedef struct { int tgt; bit rise; } ev_t;

  ev_t   pend[$];
  mst_t  mst = M_IDLE;
  int    e_idx = 0, last_rise = 0, good = 0;
  bit    prev = 1'b0, model_ready = 1'b0;
  bit    x_rise, x_fall, x_pv;
  int    x_per;

  initial begin
    ev_t ev;
    bit  hit_r;
    int  gap, p;
    x_rise = 0; x_fall = 0; x_pv = 0; x_per = 0;
    forever begin
      @(posedge clk);
      e_idx++;
      if (rst) begin
        pend.delete();
        prev = 1'b0; last_rise = e_idx; mst = M_IDLE; good = 0;
        x_rise = 0; x_fall = 0; x_pv = 0; x_per = 0;
      end else begin
        if (clk_in && !prev) pend.push_back('{e_idx + 2, 1'b1});
        if (!clk_in && prev) pend.push_back('{e_idx + 2, 1'b0});
        prev = clk_in;
        x_rise = 0; x_fall = 0; x_pv = 0; hit_r = 0;
        while (pend.size() > 0 && pend[0].tgt == e_idx) begin
          ev = pend.pop_front();
          if (ev.rise) hit_r = 1; else x_fall = 1;
        end
        if (hit_r) begin
          x_rise = 1;
          gap = e_idx - last_rise;
          p = (gap > TO + 1) ? TO + 1 : gap;
          last_rise = e_idx;
          if (mst == M_IDLE || mst == M_LOST) begin
            mst = M_ACQ; good = 0;
          end else begin
            x_pv = 1; x_per = p;
            if (p >= DE - TL && p <= DE + TL) begin
              if (mst == M_ACQ) begin
                good++;
                if (good >= LC) mst = M_LOCK;
              end
            end else begin
              mst = M_ACQ; good = 0;
            end
          end
        end else if (mst != M_LOST && (e_idx - last_rise) > TO) begin
          mst = M_LOST;
        end
      end
      model_ready = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ready) begin
        chk("rise_pulse", {31'd0, rise_pulse}, {31'd0, x_rise});
        chk("fall_pulse", {31'd0, fall_pulse}, {31'd0, x_fall});
        chk("period_valid", {31'd0, period_valid}, {31'd0, x_pv});
        chk("period", period, 32'(x_per));
        chk("locked", {31'd0, locked}, {31'd0, mst == M_LOCK});
        chk("lost", {31'd0, lost}, {31'd0, mst == M_LOST});
      end
    end
  end

  task automatic drive_period(input int p, input int hi);
    clk_in = 1'b1;
    repeat (hi) @(negedge clk);
    clk_in = 1'b0;
    repeat (p - hi) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p, hi;
    rst = 1'b1; clk_in = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      clk_in = ~clk_in;
      @(negedge clk);
    end
    chk("rst_rise", {31'd0, rise_pulse}, 32'd0);
    chk("rst_period", period, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    clk_in = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal period: lock lands on the 5th rise
    repeat (4) drive_period(100, 50);
    chk("nom_4rise_locked", {31'd0, locked}, 32'd0);
    chk("nom_period", period, 32'd100);
    drive_period(100, 50);
    chk("nom_5rise_locked", {31'd0, locked}, 32'd1);

    // Upper tolerance edge holds lock, one past it breaks lock
    repeat (3) drive_period(108, 54);
    chk("p108_locked", {31'd0, locked}, 32'd1);
    chk("p108_period", period, 32'd108);
    repeat (6) drive_period(109, 50);
    chk("p109_locked", {31'd0, locked}, 32'd0);
    chk("p109_period", period, 32'd109);

    // Relock, then loss of clock and recovery
    repeat (5) drive_period(100, 50);
    chk("relock", {31'd0, locked}, 32'd1);
    repeat (250) @(negedge clk);
    chk("lost_set", {31'd0, lost}, 32'd1);
    chk("lost_unlock", {31'd0, locked}, 32'd0);
    drive_period(100, 50);
    chk("lost_clear", {31'd0, lost}, 32'd0);
    chk("lost_period_kept", period, 32'd100);
    repeat (3) drive_period(100, 50);
    chk("after_lost_3", {31'd0, locked}, 32'd0);
    drive_period(100, 50);
    chk("after_lost_4", {31'd0, locked}, 32'd1);

    // Single short period while locked
    drive_period(50, 25);
    drive_period(100, 50);
    chk("short_period", period, 32'd50);
    chk("short_unlock", {31'd0, locked}, 32'd0);

    // Lower tolerance edge
    repeat (4) drive_period(100, 50);
    repeat (2) drive_period(92, 46);
    drive_period(100, 50);
    chk("p92_locked", {31'd0, locked}, 32'd1);
    chk("p92_period", period, 32'd92);
    drive_period(91, 45);
    drive_period(100, 50);
    chk("p91_locked", {31'd0, locked}, 32'd0);
    chk("p91_period", period, 32'd91);

    // Reset after three good periods
    repeat (4) drive_period(100, 50);
    do_reset(2);
    @(negedge clk);
    chk("mid_rst_period", period, 32'd0);
    chk("mid_rst_locked", {31'd0, locked}, 32'd0);
    repeat (4) drive_period(100, 50);
    chk("post_rst_4", {31'd0, locked}, 32'd0);
    drive_period(100, 50);
    chk("post_rst_5", {31'd0, locked}, 32'd1);

    // Randomised periods, duty, long gaps and occasional resets
    for (int i = 0; i < 60; i++) begin
      p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(150, 260))
                                      : int'($urandom_range(85, 115));
      hi = int'($urandom_range(1, p - 1));
      drive_period(p, hi);
      if ($urandom_range(0, 19) == 0) begin
        clk_in = 1'($urandom_range(0, 1));
        do_reset(int'($urandom_range(1, 3)));
      end
    end
    clk_in = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
